// File: rtl/bmp_pixel_serializer_pkg.sv
// Shared BMP constants, FSM state encoding and header byte generator
// for the pixel serializer and its FIFO.
package bmp_pixel_serializer_pkg;

    localparam int BMP_HDR_SIZE = 54;
    localparam int DIB_SIZE     = 40;
    localparam int BPP          = 24;
    localparam int FIFO_W       = 48;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HEADER = 3'd1,
        ST_PIXEL  = 3'd2,
        ST_PAD    = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    function automatic logic [7:0] le_byte(
        input logic [31:0] w,
        input logic [1:0]  off
    );
        return w[{off, 3'b000} +: 8];
    endfunction

    // Byte idx of the 54-byte BMP header; multi-byte fields little-endian.
    function automatic logic [7:0] hdr_byte(
        input logic [5:0]  idx,
        input logic [31:0] fsz,
        input logic [31:0] imgsz,
        input logic [31:0] w,
        input logic [31:0] h
    );
        logic [7:0] b;
        b = 8'h00;
        unique case (1'b1)
            (idx == 6'd0):
                b = 8'h42;
            (idx == 6'd1):
                b = 8'h4D;
            (idx >= 6'd2 && idx <= 6'd5):
                b = le_byte(fsz, 2'(idx - 6'd2));
            (idx >= 6'd10 && idx <= 6'd13):
                b = le_byte(32'(BMP_HDR_SIZE), 2'(idx - 6'd10));
            (idx >= 6'd14 && idx <= 6'd17):
                b = le_byte(32'(DIB_SIZE), 2'(idx - 6'd14));
            (idx >= 6'd18 && idx <= 6'd21):
                b = le_byte(w, 2'(idx - 6'd18));
            (idx >= 6'd22 && idx <= 6'd25):
                b = le_byte(h, 2'(idx - 6'd22));
            (idx == 6'd26):
                b = 8'd1;
            (idx == 6'd28):
                b = 8'(BPP);
            (idx >= 6'd34 && idx <= 6'd37):
                b = le_byte(imgsz, 2'(idx - 6'd34));
            default:
                b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/pixel_pair_fifo.sv
// Synchronous FIFO of pixel pairs {R1,G1,B1,R0,G0,B0}.
// Ports: push_i/pop_i, din_i/dout_o (show-ahead), full_o, empty_o.
module pixel_pair_fifo
    import bmp_pixel_serializer_pkg::*;
#(
    parameter int DW    = FIFO_W,
    parameter int DEPTH = 16
) (
    input  logic          HCLK,
    input  logic          HRESETn,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [DW-1:0] din_i,
    output logic [DW-1:0] dout_o,
    output logic          full_o,
    output logic          empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wptr_q;
    logic [AW-1:0] rptr_q;
    logic [AW:0]   cnt_q;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (cnt_q == FULL_CNT);
    assign empty_o = (cnt_q == '0);
    assign dout_o  = mem_q[rptr_q];

    // A push into a full FIFO is accepted only alongside a pop.
    always_comb begin
        do_pop  = pop_i && !empty_o;
        do_push = push_i && (!full_o || do_pop);
    end

    always_ff @(posedge HCLK) begin
        if (do_push) mem_q[wptr_q] <= din_i;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + AW'(1);
            if (do_pop)  rptr_q <= rptr_q + AW'(1);
            unique case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
                2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/bmp_pixel_serializer.sv
// Turns a 2-pixel/cycle RGB888 stream into a complete .bmp byte stream.
// In: HCLK, HRESETn, HSYNC, DATA_*; out: m_data/m_valid (m_ready), frame_done, overflow.
module bmp_pixel_serializer
    import bmp_pixel_serializer_pkg::*;
#(
    parameter int WIDTH  = 768,
    parameter int HEIGHT = 512,
    parameter int DEPTH  = 16
) (
    input  logic       HCLK,
    input  logic       HRESETn,
    input  logic       HSYNC,
    input  logic [7:0] DATA_R0,
    input  logic [7:0] DATA_G0,
    input  logic [7:0] DATA_B0,
    input  logic [7:0] DATA_R1,
    input  logic [7:0] DATA_G1,
    input  logic [7:0] DATA_B1,
    output logic [7:0] m_data,
    output logic       m_valid,
    input  logic       m_ready,
    output logic       frame_done,
    output logic       overflow
);

    localparam int ROWB  = WIDTH * 3;
    localparam int PAD   = (4 - ROWB % 4) % 4;
    localparam int PADL  = (PAD > 0) ? PAD - 1 : 0;
    localparam int IMGSZ = (ROWB + PAD) * HEIGHT;
    localparam int FSZ   = BMP_HDR_SIZE + IMGSZ;

    localparam logic [5:0]  HDR_LAST = 6'(BMP_HDR_SIZE - 1);
    localparam logic [10:0] COL_LAST = 11'(WIDTH - 2);
    localparam logic [9:0]  ROW_LAST = 10'(HEIGHT - 1);
    localparam logic [1:0]  PAD_LAST = 2'(PADL);

    state_e        state_q;
    logic [5:0]    hdr_idx_q;
    logic [2:0]    byte_idx_q;
    logic [10:0]   col_q;
    logic [9:0]    row_q;
    logic [1:0]    pad_cnt_q;
    logic [7:0]    m_data_q;
    logic          m_valid_q;
    logic          frame_done_q;
    logic          overflow_q;

    logic [FIFO_W-1:0] fifo_din;
    logic [FIFO_W-1:0] fifo_dout;
    logic          fifo_full;
    logic          fifo_empty;
    logic          xfer;
    logic          slot;
    logic          pop;
    logic          push;

    assign fifo_din = {DATA_R1, DATA_G1, DATA_B1,
                       DATA_R0, DATA_G0, DATA_B0};

    // slot: the output register is free or is emptied at this edge,
    // so a new byte may be loaded without a bubble.
    always_comb begin
        xfer = m_valid_q && m_ready;
        slot = !m_valid_q || m_ready;
        pop  = (state_q == ST_PIXEL) && slot && !fifo_empty
               && (byte_idx_q == 3'd5);
        push = HSYNC && (!fifo_full || pop);
    end

    pixel_pair_fifo #(
        .DW    (FIFO_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   (fifo_din),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Counters index the next byte to load into the output register.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q      <= ST_IDLE;
            hdr_idx_q    <= '0;
            byte_idx_q   <= '0;
            col_q        <= '0;
            row_q        <= '0;
            pad_cnt_q    <= '0;
            m_data_q     <= '0;
            m_valid_q    <= 1'b0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            if (HSYNC && fifo_full && !pop) overflow_q <= 1'b1;
            if (xfer) m_valid_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (HSYNC || !fifo_empty) begin
                        m_data_q  <= hdr_byte(6'd0, 32'(FSZ), 32'(IMGSZ),
                                              32'(WIDTH), 32'(HEIGHT));
                        m_valid_q <= 1'b1;
                        hdr_idx_q <= 6'd1;
                        state_q   <= ST_HEADER;
                    end
                end
                ST_HEADER: begin
                    if (slot) begin
                        m_data_q  <= hdr_byte(hdr_idx_q, 32'(FSZ), 32'(IMGSZ),
                                              32'(WIDTH), 32'(HEIGHT));
                        m_valid_q <= 1'b1;
                        if (hdr_idx_q == HDR_LAST) begin
                            hdr_idx_q <= '0;
                            state_q   <= ST_PIXEL;
                        end else begin
                            hdr_idx_q <= hdr_idx_q + 6'd1;
                        end
                    end
                end
                ST_PIXEL: begin
                    if (slot && !fifo_empty) begin
                        m_data_q  <= fifo_dout[{byte_idx_q, 3'b000} +: 8];
                        m_valid_q <= 1'b1;
                        if (byte_idx_q == 3'd5) begin
                            byte_idx_q <= '0;
                            if (col_q == COL_LAST) begin
                                col_q <= '0;
                                if (PAD > 0) begin
                                    state_q <= ST_PAD;
                                end else if (row_q == ROW_LAST) begin
                                    row_q   <= '0;
                                    state_q <= ST_DONE;
                                end else begin
                                    row_q <= row_q + 10'd1;
                                end
                            end else begin
                                col_q <= col_q + 11'd2;
                            end
                        end else begin
                            byte_idx_q <= byte_idx_q + 3'd1;
                        end
                    end
                end
                ST_PAD: begin
                    if (slot) begin
                        m_data_q  <= 8'h00;
                        m_valid_q <= 1'b1;
                        if (pad_cnt_q == PAD_LAST) begin
                            pad_cnt_q <= '0;
                            if (row_q == ROW_LAST) begin
                                row_q   <= '0;
                                state_q <= ST_DONE;
                            end else begin
                                row_q   <= row_q + 10'd1;
                                state_q <= ST_PIXEL;
                            end
                        end else begin
                            pad_cnt_q <= pad_cnt_q + 2'd1;
                        end
                    end
                end
                ST_DONE: begin
                    // Last byte is loaded; finish once it is taken.
                    if (xfer) begin
                        frame_done_q <= 1'b1;
                        state_q      <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign m_data     = m_data_q;
    assign m_valid    = m_valid_q;
    assign frame_done = frame_done_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_bmp_pixel_serializer.sv
// Directed bench for bmp_pixel_serializer: a 4x2 (DEPTH 4) instance and
// a 6x2 padded instance, covering header, pixels, stalls, overflow, abort.
module tb_bmp_pixel_serializer;

    logic HCLK = 1'b0;
    logic HRESETn = 1'b0;
    always #5 HCLK = ~HCLK;

    logic        hs_a, hs_b;
    logic [47:0] pa, pb;
    logic [7:0]  md_a, md_b;
    logic        mv_a, mv_b, rdy_a, rdy_b;
    logic        fd_a, fd_b, ov_a, ov_b;

    int checks = 0;
    int errors = 0;
    logic [7:0] qa[$];
    logic [7:0] qb[$];
    logic [7:0] eq[$];
    int nd_a = 0, nd_b = 0, at_a = 0, at_b = 0;
    bit sa = 0, sb = 0;
    logic [7:0] sd_a = 8'h00, sd_b = 8'h00;

    bmp_pixel_serializer #(.WIDTH(4), .HEIGHT(2), .DEPTH(4)) u_a (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSYNC(hs_a),
        .DATA_R0(pa[23:16]), .DATA_G0(pa[15:8]), .DATA_B0(pa[7:0]),
        .DATA_R1(pa[47:40]), .DATA_G1(pa[39:32]), .DATA_B1(pa[31:24]),
        .m_data(md_a), .m_valid(mv_a), .m_ready(rdy_a),
        .frame_done(fd_a), .overflow(ov_a)
    );

    bmp_pixel_serializer #(.WIDTH(6), .HEIGHT(2), .DEPTH(16)) u_b (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSYNC(hs_b),
        .DATA_R0(pb[23:16]), .DATA_G0(pb[15:8]), .DATA_B0(pb[7:0]),
        .DATA_R1(pb[47:40]), .DATA_G1(pb[39:32]), .DATA_B1(pb[31:24]),
        .m_data(md_b), .m_valid(mv_b), .m_ready(rdy_b),
        .frame_done(fd_b), .overflow(ov_b)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Pair k carries bytes 6k+1..6k+6 in B0,G0,R0,B1,G1,R1 order.
    function automatic logic [47:0] pair(input int k);
        logic [47:0] p;
        for (int j = 0; j < 6; j++) p[8*j +: 8] = 8'(6*k + j + 1);
        return p;
    endfunction

    // Hand-computed headers: 4x2 -> FSZ 78, IMG 24; 6x2 -> FSZ 94, IMG 40.
    function automatic logic [7:0] hdr_exp(input bit wide, input int i);
        case (i)
            0:  return 8'h42;
            1:  return 8'h4D;
            2:  return wide ? 8'h5E : 8'h4E;
            10: return 8'h36;
            14: return 8'h28;
            18: return wide ? 8'h06 : 8'h04;
            22: return 8'h02;
            26: return 8'h01;
            28: return 8'h18;
            34: return wide ? 8'h28 : 8'h18;
            default: return 8'h00;
        endcase
    endfunction

    task automatic build(input bit wide, input int base);
        int npr;
        npr = wide ? 3 : 2;
        eq.delete();
        for (int i = 0; i < 54; i++) eq.push_back(hdr_exp(wide, i));
        for (int r = 0; r < 2; r++) begin
            for (int p = 0; p < npr; p++) begin
                for (int j = 0; j < 6; j++)
                    eq.push_back(8'(6*(base + r*npr + p) + j + 1));
            end
            if (wide) begin
                eq.push_back(8'h00);
                eq.push_back(8'h00);
            end
        end
    endtask

    task automatic cmp_q(input string tag, input logic [7:0] got[$]);
        chk({tag, "_len"}, got.size(), eq.size());
        for (int i = 0; i < eq.size() && i < got.size(); i++)
            chk($sformatf("%s[%0d]", tag, i), 32'(got[i]), 32'(eq[i]));
    endtask

    task automatic send(input bit b, input int base, input int n);
        for (int i = 0; i < n; i++) begin
            if (b) begin hs_b = 1'b1; pb = pair(base + i); end
            else   begin hs_a = 1'b1; pa = pair(base + i); end
            @(posedge HCLK); #1;
        end
        hs_a = 1'b0;
        hs_b = 1'b0;
    endtask

    task automatic wait_done(input bit b, input int nd0, input int lim);
        int c;
        c = 0;
        while (((b ? nd_b : nd_a) == nd0) && c < lim) begin
            @(posedge HCLK); #1;
            c++;
        end
        chk(b ? "timeout_b" : "timeout_a", 32'(c < lim), 32'd1);
        repeat (3) @(posedge HCLK);
        #1;
    endtask

    always @(negedge HCLK) begin
        if (!HRESETn) begin
            sa = 0;
            sb = 0;
        end else begin
            if (sa) begin
                chk("stall_v_a", 32'(mv_a), 32'd1);
                chk("stall_d_a", 32'(md_a), 32'(sd_a));
            end
            if (sb) begin
                chk("stall_v_b", 32'(mv_b), 32'd1);
                chk("stall_d_b", 32'(md_b), 32'(sd_b));
            end
            if (mv_a && rdy_a) qa.push_back(md_a);
            if (mv_b && rdy_b) qb.push_back(md_b);
            if (fd_a) begin nd_a++; at_a = qa.size(); end
            if (fd_b) begin nd_b++; at_b = qb.size(); end
            sa = mv_a && !rdy_a;
            sb = mv_b && !rdy_b;
            sd_a = md_a;
            sd_b = md_b;
        end
    end

    initial begin
        int nd0;
        int c;
        hs_a = 1'b0; hs_b = 1'b0; pa = '0; pb = '0;
        rdy_a = 1'b1; rdy_b = 1'b1;
        repeat (3) @(posedge HCLK);
        #1;
        chk("rst_mv_a", 32'(mv_a), 32'd0);
        chk("rst_fd_a", 32'(fd_a), 32'd0);
        chk("rst_ov_a", 32'(ov_a), 32'd0);
        chk("rst_mv_b", 32'(mv_b), 32'd0);
        chk("rst_fd_b", 32'(fd_b), 32'd0);
        chk("rst_ov_b", 32'(ov_b), 32'd0);
        HRESETn = 1'b1;
        @(posedge HCLK); #1;

        // 4x2 frame, m_ready high, first-byte latency
        qa.delete();
        nd0 = nd_a;
        hs_a = 1'b1;
        pa = pair(0);
        @(posedge HCLK); #1;
        chk("lat_valid", 32'(mv_a), 32'd1);
        chk("lat_data", 32'(md_a), 32'h42);
        send(1'b0, 1, 3);
        wait_done(1'b0, nd0, 400);
        build(1'b0, 0);
        cmp_q("w4", qa);
        chk("w4_pulses", nd_a - nd0, 1);
        chk("w4_done_at", at_a, 78);

        // 6x2 frame with 2 pad bytes per row
        qb.delete();
        nd0 = nd_b;
        send(1'b1, 0, 6);
        wait_done(1'b1, nd0, 400);
        build(1'b1, 0);
        cmp_q("w6", qb);
        chk("w6_pulses", nd_b - nd0, 1);
        chk("w6_done_at", at_b, 94);

        // random backpressure on the 6x2 instance
        qb.delete();
        nd0 = nd_b;
        c = 0;
        while (nd_b == nd0 && c < 3000) begin
            hs_b = (c < 6);
            pb = pair(10 + c);
            rdy_b = 1'($urandom_range(0, 1));
            @(posedge HCLK); #1;
            c++;
        end
        hs_b = 1'b0;
        rdy_b = 1'b1;
        chk("bp_timeout", 32'(c < 3000), 32'd1);
        repeat (3) @(posedge HCLK);
        #1;
        build(1'b1, 10);
        cmp_q("bp", qb);

        // overflow: DEPTH 4, sink stalled, 5 back-to-back pairs
        qa.delete();
        nd0 = nd_a;
        rdy_a = 1'b0;
        for (int i = 0; i < 5; i++) begin
            hs_a = 1'b1;
            pa = pair(20 + i);
            @(posedge HCLK); #1;
            if (i == 3) chk("ovf_before", 32'(ov_a), 32'd0);
        end
        hs_a = 1'b0;
        chk("ovf_set", 32'(ov_a), 32'd1);
        rdy_a = 1'b1;
        wait_done(1'b0, nd0, 400);
        build(1'b0, 20);
        cmp_q("ovf", qa);
        chk("ovf_sticky", 32'(ov_a), 32'd1);
        repeat (5) @(posedge HCLK);
        #1;
        chk("ovf_idle", 32'(mv_a), 32'd0);

        // abort mid-PIXEL, then a clean frame
        qb.delete();
        send(1'b1, 30, 6);
        c = 0;
        while (qb.size() < 60 && c < 200) begin
            @(posedge HCLK); #1;
            c++;
        end
        chk("abort_reach", 32'(c < 200), 32'd1);
        HRESETn = 1'b0;
        nd0 = nd_b;
        @(posedge HCLK); #1;
        chk("abort_mv", 32'(mv_b), 32'd0);
        chk("abort_md", 32'(md_b), 32'd0);
        chk("abort_fd", 32'(fd_b), 32'd0);
        chk("abort_ov_a", 32'(ov_a), 32'd0);
        HRESETn = 1'b1;
        repeat (10) @(posedge HCLK);
        #1;
        chk("abort_flushed", 32'(mv_b), 32'd0);
        chk("abort_no_done", nd_b - nd0, 0);
        qb.delete();
        nd0 = nd_b;
        send(1'b1, 36, 6);
        wait_done(1'b1, nd0, 400);
        build(1'b1, 36);
        cmp_q("abort_new", qb);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
